// File: rtl/ctrl_pkg.sv
// Shared encodings for the cpu_controller slice: opcodes, FSM states,
// pc_ctrl / alu_func codes, instruction field positions and decoded classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_PCINC  = 3'd5,
    ST_JUMP   = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_JUMP    = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVB = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_JUMP = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  localparam logic [2:0] ALU_MOVB = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam int IR_OP_MSB  = 15;
  localparam int IR_OP_LSB  = 12;
  localparam int IR_RD_MSB  = 11;
  localparam int IR_RD_LSB  = 10;
  localparam int IR_RS_MSB  = 9;
  localparam int IR_RS_LSB  = 8;
  localparam int IR_OFF_MSB = 7;
  localparam int IR_OFF_LSB = 0;

  function automatic logic [3:0] rd_onehot(input logic [1:0] rd_sel);
    return 4'b0001 << rd_sel;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: maps an opcode to ALU function, operand
// select and the instruction class that steers the controller FSM.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_func_o,
  output logic       alu_in_sel_o,
  output op_class_e  class_o
);

  always_comb begin
    alu_func_o   = ALU_MOVB;
    alu_in_sel_o = 1'b0;
    class_o      = CLS_ILLEGAL;
    case (opcode_i)
      OP_NOP:  class_o = CLS_NOP;
      OP_MOVB: class_o = CLS_ALU;
      OP_ADD:  begin alu_func_o = ALU_ADD; alu_in_sel_o = 1'b1; class_o = CLS_ALU; end
      OP_SUB:  begin alu_func_o = ALU_SUB; alu_in_sel_o = 1'b1; class_o = CLS_ALU; end
      OP_AND:  begin alu_func_o = ALU_AND; alu_in_sel_o = 1'b1; class_o = CLS_ALU; end
      OP_OR:   begin alu_func_o = ALU_OR;  alu_in_sel_o = 1'b1; class_o = CLS_ALU; end
      OP_JUMP: class_o = CLS_JUMP;
      OP_HALT: class_o = CLS_HALT;
      default: class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute controller driving data_path.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap to HALT).
module cpu_controller
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ins,
  input  logic        ins_valid,
  output logic        ins_rd,
  input  logic        en_out,
  output logic        en_pc,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset,
  output logic        en_in,
  output logic        alu_in_sel,
  output logic [2:0]  alu_func,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic [3:0]  reg_en,
  output logic        busy,
  output logic        halted,
  output logic        err
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              illegal_d;
  op_class_e         dec_class;

  ctrl_decoder u_decoder (
    .opcode_i     (ir_q[IR_OP_MSB:IR_OP_LSB]),
    .alu_func_o   (alu_func),
    .alu_in_sel_o (alu_in_sel),
    .class_o      (dec_class)
  );

  assign rd     = ir_q[IR_RD_MSB:IR_RD_LSB];
  assign rs     = ir_q[IR_RS_MSB:IR_RS_LSB];
  assign offset = ir_q[IR_OFF_MSB:IR_OFF_LSB];
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
      wait_q  <= {WAIT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  logic illegal_unused;
  assign illegal_unused = illegal_d;
`endif

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    err_d     = err_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`else
    illegal_d = 1'b0;
`endif
    ins_rd    = 1'b0;
    en_pc     = 1'b0;
    pc_ctrl   = PC_HOLD;
    en_in     = 1'b0;
    reg_en    = 4'b0000;
    busy      = 1'b1;
    halted    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        ins_rd = 1'b1;
        if (ins_valid) begin
          ir_d    = ins;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_ALU: begin
            wait_d  = {WAIT_W{1'b0}};
            state_d = ST_EXEC;
          end
          CLS_JUMP: state_d = ST_JUMP;
          CLS_HALT: state_d = ST_HALT;
          CLS_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = ST_HALT;
`else
            state_d   = ST_PCINC;
`endif
          end
          default: state_d = ST_PCINC;
        endcase
      end
      ST_EXEC: begin
        en_in = 1'b1;
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (en_out) begin
          state_d = ST_WB;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          wait_d  = {WAIT_W{1'b0}};
          state_d = ST_PCINC;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_en  = rd_onehot(rd);
        state_d = ST_PCINC;
      end
      ST_PCINC, ST_JUMP: begin
        en_pc   = 1'b1;
        pc_ctrl = (state_q == ST_JUMP) ? PC_JMP : PC_INC;
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_HALT: begin
        busy    = 1'b0;
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller; an instruction-level model
// lays out the expected output trace cycle by cycle for each instruction.
module tb_cpu_controller;

  localparam int MAX_WAIT = 8;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, ins_valid, en_out;
  logic [15:0] ins;
  logic        ins_rd, en_pc, en_in, alu_in_sel, busy, halted, err, illegal_s;
  logic [1:0]  pc_ctrl, rd, rs;
  logic [7:0]  offset;
  logic [2:0]  alu_func;
  logic [3:0]  reg_en;

  cpu_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .ins(ins), .ins_valid(ins_valid),
    .ins_rd(ins_rd), .en_out(en_out), .en_pc(en_pc), .pc_ctrl(pc_ctrl),
    .offset(offset), .en_in(en_in), .alu_in_sel(alu_in_sel), .alu_func(alu_func),
    .rd(rd), .rs(rs), .reg_en(reg_en), .busy(busy), .halted(halted), .err(err)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal_s)
`endif
  );
`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal_s = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ins_rd;
    logic       en_pc;
    logic [1:0] pc_ctrl;
    logic [7:0] offset;
    logic       en_in;
    logic       alu_in_sel;
    logic [2:0] alu_func;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] reg_en;
    logic       busy;
    logic       halted;
    logic       err;
    logic       illegal;
  } obs_t;

  obs_t act, exp_v, last, dec_obs;
  assign act = {ins_rd, en_pc, pc_ctrl, offset, en_in, alu_in_sel, alu_func,
                rd, rs, reg_en, busy, halted, err, illegal_s};

  int checks = 0, errors = 0;
  bit exp_on = 1'b0;

  // Model state: last fetched word, sticky flags, where the controller sits.
  logic [15:0] m_ir;
  bit          m_err, m_ill;
  int          m_loc;

  int         n_en_in, n_reg_en, n_pc, n_ins_rd;
  logic [3:0] reg_or;
  logic [1:0] pc_or;
  logic       first_fetch_rd;

  always @(negedge clk) begin
    if (exp_on) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_trace t=%0t got=%h expected=%h", $time, act, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic obs_t mbase(input bit busy_b);
    obs_t o;
    logic [3:0] op;
    o = '0;
    op = m_ir[15:12];
    o.offset = m_ir[7:0];
    o.rd = m_ir[11:10];
    o.rs = m_ir[9:8];
    if (op >= 4'd2 && op <= 4'd5) begin
      o.alu_func = 3'(op - 4'd1);
      o.alu_in_sel = 1'b1;
    end
    o.busy = busy_b;
    o.err = m_err;
    o.illegal = m_ill;
    return o;
  endfunction

  task automatic step(input obs_t e);
    exp_v = e;
    exp_on = 1'b1;
    @(negedge clk);
    last = act;
    n_en_in += int'(act.en_in);
    if (act.reg_en != 4'b0000) n_reg_en++;
    reg_or |= act.reg_en;
    if (act.en_pc) n_pc++;
    pc_or |= act.pc_ctrl;
    n_ins_rd += int'(act.ins_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ins_valid = 1'($urandom_range(0, 1));
    ins = 16'($urandom);
    en_out = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; ins_valid = 1'b0; en_out = 1'b0; ins = 16'h0000;
    m_ir = 16'h0000; m_err = 1'b0; m_ill = 1'b0; m_loc = 0;
    #1;
    chk("reset_zero", 32'(act), 32'd0);
    step(mbase(1'b0));
    step(mbase(1'b0));
    rst = 1'b1;
  endtask

  task automatic fin(input logic [1:0] pc, input bit keep);
    obs_t e;
    noise();
    start = keep;
    e = mbase(1'b1);
    e.en_pc = 1'b1;
    e.pc_ctrl = pc;
    step(e);
    m_loc = keep ? 1 : 0;
  endtask

  // lat: cycle of EXEC on which en_out arrives; 0 or > MAX_WAIT means never.
  task automatic run_instr(input logic [15:0] w, input int fd, input int lat,
                           input bit keep, input bit abort);
    obs_t e;
    logic [3:0] op;
    int ne;
    n_en_in = 0; n_reg_en = 0; n_pc = 0; n_ins_rd = 0;
    reg_or = 4'b0000; pc_or = 2'b00;
    if (m_loc == 0) begin
      repeat ($urandom_range(0, 2)) begin
        noise(); start = 1'b0; step(mbase(1'b0));
      end
      noise(); start = 1'b1; step(mbase(1'b0));
      m_loc = 1;
    end
    for (int i = 0; i <= fd; i++) begin
      noise();
      ins_valid = (i == fd);
      if (i == fd) ins = w;
      e = mbase(1'b1);
      e.ins_rd = 1'b1;
      step(e);
      if (i == 0) first_fetch_rd = last.ins_rd;
    end
    m_ir = w;
    noise();
    step(mbase(1'b1));
    dec_obs = last;
    op = w[15:12];
    if (op >= 4'd1 && op <= 4'd5) begin
      ne = (lat >= 1 && lat <= MAX_WAIT) ? lat : MAX_WAIT;
      for (int c = 1; c <= ne; c++) begin
        noise();
        en_out = (c == lat);
        e = mbase(1'b1);
        e.en_in = 1'b1;
        step(e);
        if (abort && c == 2) begin
          rst = 1'b0;
          #1;
          chk("reset_mid_exec", 32'(act), 32'd0);
          m_ir = 16'h0000; m_err = 1'b0; m_ill = 1'b0;
          step(mbase(1'b0));
          rst = 1'b1;
          noise(); start = 1'b1;
          step(mbase(1'b0));
          noise(); ins_valid = 1'b0;
          e = mbase(1'b1);
          e.ins_rd = 1'b1;
          step(e);
          chk("ins_rd_after_reset", 32'(last.ins_rd), 32'd1);
          m_loc = 1;
          return;
        end
      end
      if (lat >= 1 && lat <= MAX_WAIT) begin
        noise();
        e = mbase(1'b1);
        e.reg_en = 4'b0001 << w[11:10];
        step(e);
      end else begin
        m_err = 1'b1;
      end
      fin(2'b01, keep);
    end else if (op == 4'd6) begin
      fin(2'b10, keep);
    end else if (op == 4'd7 || (op >= 4'd8 && TRAP)) begin
      if (op >= 4'd8) m_ill = 1'b1;
      m_loc = 2;
      n_ins_rd = 0;
      repeat (5) begin
        noise();
        e = mbase(1'b0);
        e.halted = 1'b1;
        step(e);
      end
    end else begin
      fin(2'b01, keep);
    end
  endtask

  initial begin
    logic [15:0] alu_words [4];
    logic [2:0]  alu_funcs [4];
    logic [3:0]  rop;
    alu_words = '{16'h2600, 16'h3600, 16'h4600, 16'h5600};
    alu_funcs = '{3'b001, 3'b010, 3'b011, 3'b100};

    do_reset();

    run_instr(16'h2600, 1, 50, 1'b1, 1'b1);

    run_instr(16'h1401, 0, 3, 1'b1, 1'b0);
    chk("movb_func", 32'(dec_obs.alu_func), 32'd0);
    chk("movb_sel", 32'(dec_obs.alu_in_sel), 32'd0);
    chk("movb_offset", 32'(dec_obs.offset), 32'h01);
    chk("movb_reg_en", 32'(reg_or), 32'b0010);
    chk("movb_reg_en_cnt", 32'(n_reg_en), 32'd1);
    chk("movb_pc_cnt", 32'(n_pc), 32'd1);
    chk("movb_pc_ctrl", 32'(pc_or), 32'b01);

    for (int k = 0; k < 4; k++) begin
      run_instr(alu_words[k], k, 1, 1'b1, 1'b0);
      chk("alu_func", 32'(dec_obs.alu_func), 32'(alu_funcs[k]));
      chk("alu_sel", 32'(dec_obs.alu_in_sel), 32'd1);
      chk("alu_rd_rs", 32'({dec_obs.rd, dec_obs.rs}), 32'b0110);
      chk("alu_reg_en", 32'(reg_or), 32'b0010);
    end

    run_instr(16'h6078, 1, 0, 1'b1, 1'b0);
    chk("jump_pc_cnt", 32'(n_pc), 32'd1);
    chk("jump_pc_ctrl", 32'(pc_or), 32'b10);
    chk("jump_offset", 32'(dec_obs.offset), 32'h78);
    chk("jump_no_exec", 32'(n_en_in + n_reg_en), 32'd0);
    run_instr(16'h0000, 0, 0, 1'b1, 1'b0);
    chk("fetch_after_jump", 32'(first_fetch_rd), 32'd1);
    chk("nop_pc_ctrl", 32'(pc_or), 32'b01);

    run_instr(16'h2600, 0, MAX_WAIT, 1'b1, 1'b0);
    chk("lastcycle_en_in", 32'(n_en_in), 32'd8);
    chk("lastcycle_write", 32'(n_reg_en), 32'd1);
    chk("lastcycle_no_err", 32'(last.err), 32'd0);

    run_instr(16'h2600, 0, 0, 1'b0, 1'b0);
    chk("timeout_en_in", 32'(n_en_in), 32'd8);
    chk("timeout_err", 32'(last.err), 32'd1);
    chk("timeout_no_write", 32'(n_reg_en), 32'd0);
    chk("timeout_pc_ctrl", 32'(pc_or), 32'b01);

    run_instr(16'hF000, 0, 0, 1'b1, 1'b0);
    if (TRAP) begin
      chk("illegal_flag", 32'(last.illegal), 32'd1);
      chk("illegal_halted", 32'(last.halted), 32'd1);
      chk("illegal_no_fetch", 32'(n_ins_rd), 32'd0);
      do_reset();
    end else begin
      chk("illegal_as_nop", 32'(pc_or), 32'b01);
      chk("illegal_pc_cnt", 32'(n_pc), 32'd1);
    end

    run_instr(16'h7000, 0, 0, 1'b1, 1'b0);
    chk("halt_halted", 32'(last.halted), 32'd1);
    chk("halt_no_fetch", 32'(n_ins_rd), 32'd0);
    do_reset();

    repeat (200) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'd7 && $urandom_range(0, 3) != 0) rop = 4'd2;
      run_instr({rop, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 11),
                $urandom_range(0, 3) != 0, 1'b0);
      if (m_loc == 2) do_reset();
    end

    exp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
